vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture_if.sv | 28 ++
 rtl/vga_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_capture.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// Video bus into the frame capture block: pixel clock, sync, blanking and colour.
// The source side drives every signal; the capture side only observes them.
interface vga_capture_if;
    logic       vga_clk;
    logic       vsync;
    logic       vga_blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (
        output vga_clk,
        output vsync,
        output vga_blank_n,
        output r,
        output g,
        output b
    );

    modport slave (
        input vga_clk,
        input vsync,
        input vga_blank_n,
        input r,
        input g,
        input b
    );
endinterface

// File: rtl/vga_capture.sv
// VGA frame capture: tracks frames between vsync falling edges, accumulates a
// per-frame checksum, samples one probe pixel, counts lines and flags frames
// whose geometry differs from H_ACTIVE x V_ACTIVE.
// Build option: define VGA_CAPTURE_CRC_EN to make the checksum a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over r, g, b bytes;
// without it the checksum is the 16-bit wrapping sum of r + g + b.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic         clk,
    input  logic         rst,
    vga_capture_if.slave vid,
    input  logic [9:0]   probe_x,
    input  logic [9:0]   probe_y,
    output logic [23:0]  probe_rgb,
    output logic [15:0]  frame_sum,
    output logic         frame_done,
    output logic [7:0]   frame_count,
    output logic [9:0]   line_count,
    output logic         geom_err,
    output logic         locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VSYNC = 2'd1,
        FRAME = 2'd2
    } state_t;

    localparam logic [9:0]  COORD_MAX  = 10'd1023;
    localparam logic [31:0] H_ACTIVE_U = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACTIVE_U = 32'(V_ACTIVE);

    // Coordinates stick at the top of their range instead of wrapping, so an
    // overlong line or frame can never alias back onto a valid coordinate.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == COORD_MAX) ? v : v + 10'd1;
    endfunction

`ifdef VGA_CAPTURE_CRC_EN
    localparam logic [15:0] SUM_INIT = 16'hFFFF;

    // One byte of CRC-16-CCITT, MSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sum_step(input logic [15:0] s,
                                             input logic [7:0]  rr,
                                             input logic [7:0]  gg,
                                             input logic [7:0]  bb);
        return crc_byte(crc_byte(crc_byte(s, rr), gg), bb);
    endfunction
`else
    localparam logic [15:0] SUM_INIT = 16'h0000;

    function automatic logic [15:0] sum_step(input logic [15:0] s,
                                             input logic [7:0]  rr,
                                             input logic [7:0]  gg,
                                             input logic [7:0]  bb);
        return s + {8'h00, rr} + {8'h00, gg} + {8'h00, bb};
    endfunction
`endif

    state_t      state;
    state_t      state_next;

    logic        vga_clk_prev;
    logic        strobe;
    logic        blank_prev;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] sum;
    logic        err;
    logic [23:0] probe_work;

    logic        clear_frame;
    logic        track;
    logic        publish;

    logic        blank_upd;
    logic [9:0]  x_upd;
    logic [9:0]  y_upd;
    logic [15:0] sum_upd;
    logic        err_upd;
    logic [23:0] work_upd;
    logic        probe_in_range;

    // One strobe per pixel: the clk edge that first sees vga_clk high.
    assign strobe = vid.vga_clk & ~vga_clk_prev;

    assign probe_in_range = ({22'd0, probe_x} < H_ACTIVE_U) &&
                            ({22'd0, probe_y} < V_ACTIVE_U);

    // Pixel clock edge detector history.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_clk_prev <= 1'b0;
        end else begin
            vga_clk_prev <= vid.vga_clk;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a frame spans vsync rising edge to the next falling edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!vid.vsync) state_next = VSYNC;
            VSYNC:   if (vid.vsync)  state_next = FRAME;
            FRAME:   if (!vid.vsync) state_next = VSYNC;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: clear the working set during sync, accumulate in a frame,
    // and publish on the vsync falling edge that closes a tracked frame.
    always_comb begin
        clear_frame = 1'b0;
        track       = 1'b0;
        publish     = 1'b0;
        locked      = 1'b0;
        case (state)
            VSYNC: clear_frame = 1'b1;
            FRAME: begin
                track   = 1'b1;
                locked  = 1'b1;
                publish = ~vid.vsync;
            end
            default: ;
        endcase
    end

    // Effect of this clk's strobe on the working set. Publishing reads these
    // updated values so a line end on the frame-end clk is counted first.
    always_comb begin
        blank_upd = blank_prev;
        x_upd     = x;
        y_upd     = y;
        sum_upd   = sum;
        err_upd   = err;
        work_upd  = probe_work;
        if (strobe) begin
            blank_upd = vid.vga_blank_n;
            if (vid.vga_blank_n) begin
                sum_upd = sum_step(sum, vid.r, vid.g, vid.b);
                if ((x == probe_x) && (y == probe_y)) begin
                    work_upd = {vid.r, vid.g, vid.b};
                end
                x_upd = sat_inc(x);
            end else if (blank_prev) begin
                if ({22'd0, x} != H_ACTIVE_U) begin
                    err_upd = 1'b1;
                end
                x_upd = '0;
                y_upd = sat_inc(y);
            end
        end
    end

    // Working set for the frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_prev <= 1'b0;
            x          <= '0;
            y          <= '0;
            sum        <= '0;
            err        <= 1'b0;
            probe_work <= '0;
        end else if (clear_frame) begin
            blank_prev <= 1'b0;
            x          <= '0;
            y          <= '0;
            sum        <= SUM_INIT;
            err        <= 1'b0;
            probe_work <= '0;
        end else if (track) begin
            blank_prev <= blank_upd;
            x          <= x_upd;
            y          <= y_upd;
            sum        <= sum_upd;
            err        <= err_upd;
            probe_work <= work_upd;
        end
    end

    // Published results: updated only at frame end, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_rgb   <= '0;
            frame_sum   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_count  <= '0;
            geom_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (publish) begin
                frame_sum   <= sum_upd;
                line_count  <= y_upd;
                probe_rgb   <= probe_in_range ? work_upd : 24'h000000;
                geom_err    <= err_upd | ({22'd0, y_upd} != V_ACTIVE_U);
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture on a reduced 8x8 raster. Frames are described as
// pixel arrays; expected results come from a reference model over those arrays.
module tb_vga_capture;

    localparam int TB_H = 8;
    localparam int TB_V = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic [23:0] probe_rgb;
    logic [15:0] frame_sum;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic [9:0]  line_count;
    logic        geom_err;
    logic        locked;

    vga_capture_if vid();

    vga_capture #(
        .H_ACTIVE (TB_H),
        .V_ACTIVE (TB_V)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vid         (vid),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .probe_rgb   (probe_rgb),
        .frame_sum   (frame_sum),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .line_count  (line_count),
        .geom_err    (geom_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_total = 0;

    // Frame description used by the player and the reference model.
    logic [23:0] pix [0:15][0:15];
    int          len [0:15];
    int          nlines;

    logic [15:0] exp_sum;
    logic [9:0]  exp_lines;
    logic        exp_err;
    logic [23:0] exp_probe;

    typedef struct {
        logic [23:0] fill;
        int          sx;
        int          sy;
        logic [23:0] sc;
        int          px;
        int          py;
        int          bad_line;
        int          bad_len;
        int          nl;
        logic [15:0] e_sum;
        logic [9:0]  e_lines;
        logic        e_err;
        logic [23:0] e_probe;
    } vec_t;

    vec_t vecs [0:7];

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_total <= done_total + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference checksum step: bit-serial CRC over the 24-bit pixel, or plain sum.
    function automatic logic [15:0] ref_add(input logic [15:0] s, input logic [23:0] p);
`ifdef VGA_CAPTURE_CRC_EN
        logic [15:0] c;
        c = s;
        for (int k = 23; k >= 0; k--) begin
            c = (c[15] ^ p[k]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
`else
        int t;
        t = int'(s) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
        return 16'(t % 65536);
`endif
    endfunction

    function automatic void model(input int px, input int py);
        logic [15:0] s;
        logic        e;
`ifdef VGA_CAPTURE_CRC_EN
        s = 16'hFFFF;
`else
        s = 16'h0000;
`endif
        e = (nlines != TB_V);
        for (int l = 0; l < nlines; l++) begin
            if (len[l] != TB_H) e = 1'b1;
            for (int p = 0; p < len[l]; p++) s = ref_add(s, pix[l][p]);
        end
        exp_sum   = s;
        exp_lines = 10'(nlines);
        exp_err   = e;
        if (px < TB_H && py < TB_V && py < nlines && px < len[py])
            exp_probe = pix[py][px];
        else
            exp_probe = 24'h0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe_px(input logic blank, input logic [23:0] c);
        vid.vga_blank_n = blank;
        {vid.r, vid.g, vid.b} = c;
        vid.vga_clk = 1'b1;
        tick();
        vid.vga_clk = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        vid.vsync = 1'b1;
        tick();
        tick();
    endtask

    task automatic play_lines(input int first, input int last);
        for (int l = first; l <= last; l++) begin
            for (int p = 0; p < len[l]; p++) strobe_px(1'b1, pix[l][p]);
            strobe_px(1'b0, 24'h0);
        end
    endtask

    task automatic end_frame(output int pulses);
        vid.vsync   = 1'b0;
        vid.vga_clk = 1'b0;
        pulses = 0;
        repeat (4) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
    endtask

    task automatic fill_frame(input logic [23:0] fill, input int nl);
        nlines = nl;
        for (int l = 0; l < 16; l++) begin
            len[l] = TB_H;
            for (int p = 0; p < 16; p++) pix[l][p] = fill;
        end
    endtask

    task automatic check_results(input string tag, input logic [15:0] e_sum,
                                 input logic [9:0] e_lines, input logic e_err,
                                 input logic [23:0] e_probe);
        chk({tag, "_sum"},   32'(frame_sum),  32'(e_sum));
        chk({tag, "_lines"}, 32'(line_count), 32'(e_lines));
        chk({tag, "_err"},   32'(geom_err),   32'(e_err));
        chk({tag, "_probe"}, 32'(probe_rgb),  32'(e_probe));
    endtask

    initial begin
        int pulses;
        int extra;
        int snap;
        logic [15:0] want_sum;

        vecs[0] = '{24'h010101, -1, -1, 24'h0,      0, 0, -1, 0, 8, 16'h00C0, 10'd8, 1'b0, 24'h010101};
        vecs[1] = '{24'h000000,  5,  7, 24'h123456, 5, 7, -1, 0, 8, 16'h009C, 10'd8, 1'b0, 24'h123456};
        vecs[2] = '{24'hFFFFFF, -1, -1, 24'h0,      7, 7, -1, 0, 8, 16'hBF40, 10'd8, 1'b0, 24'hFFFFFF};
        vecs[3] = '{24'h010203, -1, -1, 24'h0,      2, 3,  3, 7, 8, 16'h017A, 10'd8, 1'b1, 24'h010203};
        vecs[4] = '{24'h010203, -1, -1, 24'h0,      8, 0, -1, 0, 8, 16'h0180, 10'd8, 1'b0, 24'h000000};
        vecs[5] = '{24'h000001, -1, -1, 24'h0,      0, 7, -1, 0, 7, 16'h0038, 10'd7, 1'b1, 24'h000000};
        vecs[6] = '{24'h000100, -1, -1, 24'h0,      7, 0,  0, 9, 8, 16'h0041, 10'd8, 1'b1, 24'h000100};
        vecs[7] = '{24'h000002, -1, -1, 24'h0,      0, 8, -1, 0, 9, 16'h0090, 10'd9, 1'b1, 24'h000000};

        rst = 1'b1;
        vid.vga_clk = 1'b0;
        vid.vsync = 1'b1;
        vid.vga_blank_n = 1'b0;
        vid.r = 8'h0;
        vid.g = 8'h0;
        vid.b = 8'h0;
        probe_x = '0;
        probe_y = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        chk("rst_sum",   32'(frame_sum),   32'h0);
        chk("rst_count", 32'(frame_count), 32'h0);
        chk("rst_lines", 32'(line_count),  32'h0);
        chk("rst_err",   32'(geom_err),    32'h0);
        chk("rst_probe", 32'(probe_rgb),   32'h0);
        chk("rst_done",  32'(frame_done),  32'h0);
        chk("rst_lock",  32'(locked),      32'h0);

        vid.vsync = 1'b0;
        tick();
        tick();

        // Directed frames from the table.
        for (int i = 0; i < 8; i++) begin
            fill_frame(vecs[i].fill, vecs[i].nl);
            if (vecs[i].sx >= 0) pix[vecs[i].sy][vecs[i].sx] = vecs[i].sc;
            if (vecs[i].bad_line >= 0) len[vecs[i].bad_line] = vecs[i].bad_len;
            probe_x = 10'(vecs[i].px);
            probe_y = 10'(vecs[i].py);
            model(vecs[i].px, vecs[i].py);
`ifdef VGA_CAPTURE_CRC_EN
            want_sum = exp_sum;
`else
            want_sum = vecs[i].e_sum;
`endif
            start_frame();
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'h1);
            play_lines(0, nlines - 1);
            end_frame(pulses);
            chk($sformatf("vec%0d_done", i), 32'(pulses), 32'd1);
            check_results($sformatf("vec%0d", i), want_sum, vecs[i].e_lines,
                          vecs[i].e_err, vecs[i].e_probe);
            chk($sformatf("vec%0d_count", i), 32'(frame_count), 32'(i + 1));
        end

        // Randomized frames against the reference model.
        for (int k = 0; k < 20; k++) begin
            int px;
            int py;
            fill_frame(24'h0, ($urandom_range(0, 3) == 0) ? 7 + $urandom_range(0, 2) : 8);
            for (int l = 0; l < nlines; l++) begin
                len[l] = ($urandom_range(0, 5) == 0) ? 7 + $urandom_range(0, 2) : 8;
                for (int p = 0; p < 16; p++) pix[l][p] = 24'($urandom);
            end
            px = $urandom_range(0, 9);
            py = $urandom_range(0, 9);
            probe_x = 10'(px);
            probe_y = 10'(py);
            model(px, py);
            start_frame();
            play_lines(0, nlines - 1);
            end_frame(pulses);
            chk($sformatf("rnd%0d_done", k), 32'(pulses), 32'd1);
            check_results($sformatf("rnd%0d", k), exp_sum, exp_lines, exp_err, exp_probe);
        end

        // Last line end and frame end on the same clk: line is counted first.
        fill_frame(24'h000003, 8);
        probe_x = 10'd1;
        probe_y = 10'd7;
        model(1, 7);
        start_frame();
        play_lines(0, 6);
        for (int p = 0; p < TB_H; p++) strobe_px(1'b1, pix[7][p]);
        vid.vga_blank_n = 1'b0;
        vid.vsync = 1'b0;
        vid.vga_clk = 1'b1;
        tick();
        pulses = (frame_done === 1'b1) ? 1 : 0;
        end_frame(extra);
        chk("coinc_done", 32'(pulses + extra), 32'd1);
        check_results("coinc", exp_sum, exp_lines, exp_err, exp_probe);

        // Line counter saturates at 1023.
        probe_x = 10'd0;
        probe_y = 10'd0;
        start_frame();
        for (int l = 0; l < 1030; l++) begin
            strobe_px(1'b1, 24'h0);
            strobe_px(1'b0, 24'h0);
        end
        end_frame(pulses);
        chk("ysat_done",  32'(pulses),     32'd1);
        chk("ysat_lines", 32'(line_count), 32'd1023);
        chk("ysat_err",   32'(geom_err),   32'd1);

        // Reset in the middle of a frame: partial frame is discarded.
        fill_frame(24'h000001, 8);
        probe_x = 10'd0;
        probe_y = 10'd0;
        model(0, 0);
        start_frame();
        play_lines(0, 3);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 32'(frame_count), 32'h0);
        chk("mid_rst_lock",  32'(locked),      32'h0);
        chk("mid_rst_sum",   32'(frame_sum),   32'h0);
        play_lines(4, 7);
        end_frame(pulses);
        chk("mid_rst_nodone", 32'(pulses), 32'd0);
        start_frame();
        play_lines(0, 7);
        end_frame(pulses);
        chk("mid_rst_done",  32'(pulses),      32'd1);
        chk("mid_rst_first", 32'(frame_count), 32'd1);
        check_results("mid_rst", exp_sum, exp_lines, exp_err, exp_probe);

        // 256 good frames from reset: counter wraps back to zero.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vid.vsync = 1'b0;
        tick();
        tick();
        snap = done_total;
        for (int f = 0; f < 256; f++) begin
            start_frame();
            play_lines(0, 7);
            vid.vsync = 1'b0;
            tick();
            tick();
            if (f == 0) chk("wrap_first_count", 32'(frame_count), 32'd1);
        end
        tick();
        tick();
        chk("wrap_pulses", 32'(done_total - snap), 32'd256);
        chk("wrap_count",  32'(frame_count),       32'd0);
        chk("wrap_err",    32'(geom_err),          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
